// File: rtl/mux_pkg.sv
// Shared constants for the round-robin / fixed-select output multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/mux_rr_n_arbiter.sv
// Rotating-priority arbiter: search starts at ptr and wraps modulo N_CH.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             advance,
    output logic [N_CH-1:0]  gnt,
    output logic [SEL_W-1:0] gnt_idx,
    output logic [SEL_W-1:0] ptr
);

    logic found;
    int   cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_CH; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N_CH) cand = cand - N_CH;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = SEL_W'(cand);
            end
        end
    end

    // Next search starts just past the channel that was served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            if (gnt_idx == SEL_W'(N_CH - 1)) ptr <= '0;
            else ptr <= gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel registered valid/ready multiplexer with fixed-select
// and round-robin modes; one-cycle latency, full throughput.
module mux_rr_n
    import mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready
);

    logic [N_CH-1:0]  fix_gnt;
    logic [N_CH-1:0]  rr_gnt;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] ptr;
    logic [WIDTH-1:0] mux_data;
    logic [SEL_W-1:0] mux_ch;
    logic             load;
    logic             fire;
    logic             advance;

    // Out-of-range select (non power-of-two N_CH) grants nobody.
    always_comb begin
        fix_gnt = '0;
        if (int'(sel) < N_CH) fix_gnt[sel] = in_valid[sel];
    end

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (advance),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .ptr     (ptr)
    );

    assign grant    = (mode == MODE_RR) ? rr_gnt : fix_gnt;
    assign load     = !out_valid || out_ready;
    assign in_ready = grant & {N_CH{load && !rst}};
    assign fire     = |in_ready;
    assign advance  = fire && (mode == MODE_RR);

    always_comb begin
        mux_data = '0;
        mux_ch   = '0;
        for (int i = 0; i < N_CH; i++) begin
            mux_data = mux_data |
                (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
            mux_ch = mux_ch | (SEL_W'(i) & {SEL_W{grant[i]}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load) begin
            if (fire) begin
                out_valid <= 1'b1;
                out_data  <= mux_data;
                out_ch    <= mux_ch;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// Randomized and directed bench for mux_rr_n at N_CH=4 and N_CH=3,
// checked against a transaction-level reference model.
module tb_mux_rr_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  v;
    logic [31:0] d;
    logic        out_ready;

    logic [3:0]  ir4;
    logic        ov4;
    logic [7:0]  od4;
    logic [1:0]  oc4;
    logic [2:0]  ir3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_ptr [2];
    bit          m_ov  [2];
    logic [7:0]  m_od  [2];
    int          m_oc  [2];
    int          acc   [2];

    always #5 clk = ~clk;

    mux_rr_n #(.N_CH(4), .WIDTH(8)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (v),
        .in_data   (d),
        .in_ready  (ir4),
        .out_valid (ov4),
        .out_data  (od4),
        .out_ch    (oc4),
        .out_ready (out_ready)
    );

    mux_rr_n #(.N_CH(3), .WIDTH(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (v[2:0]),
        .in_data   (d[23:0]),
        .in_ready  (ir3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_ch    (oc3),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    // Channel that wins under the stated rules, or -1 for no grant.
    function automatic int grant_of(input int n, input int md, input int s,
                                    input logic [3:0] vv, input int p);
        if (md == 0) begin
            if (s < n && vv[s]) return s;
            return -1;
        end
        for (int k = 0; k < n; k++)
            if (vv[(p + k) % n]) return (p + k) % n;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0;
            m_ov[k]  = 0;
            m_od[k]  = 8'h00;
            m_oc[k]  = 0;
            acc[k]   = -1;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at next negedge.
    task automatic tick();
        int n;
        int gi;
        bit ld;
        logic [3:0] vv;
        #1;
        for (int k = 0; k < 2; k++) begin
            n  = (k == 0) ? 4 : 3;
            vv = (k == 0) ? v : {1'b0, v[2:0]};
            gi = grant_of(n, int'(mode), int'(sel), vv, m_ptr[k]);
            ld = !m_ov[k] || out_ready;
            acc[k] = (gi >= 0 && ld) ? gi : -1;
            if (k == 0)
                chk("in_ready4", int'(ir4), acc[k] >= 0 ? (1 << gi) : 0);
            else
                chk("in_ready3", int'(ir3), acc[k] >= 0 ? (1 << gi) : 0);
            if (ld) begin
                if (gi >= 0) begin
                    m_ov[k] = 1;
                    m_od[k] = 8'((d >> (gi * 8)) & 32'hFF);
                    m_oc[k] = gi;
                    if (mode) m_ptr[k] = (gi + 1) % n;
                end else begin
                    m_ov[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid4", int'(ov4), int'(m_ov[0]));
        chk("out_data4",  int'(od4), int'(m_od[0]));
        chk("out_ch4",    int'(oc4), m_oc[0]);
        chk("out_valid3", int'(ov3), int'(m_ov[1]));
        chk("out_data3",  int'(od3), int'(m_od[1]));
        chk("out_ch3",    int'(oc3), m_oc[1]);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid4", int'(ov4), 0);
        chk("rst_data4",  int'(od4), 0);
        chk("rst_ch4",    int'(oc4), 0);
        chk("rst_ready4", int'(ir4), 0);
        chk("rst_valid3", int'(ov3), 0);
        chk("rst_data3",  int'(od3), 0);
        chk("rst_ch3",    int'(oc3), 0);
        chk("rst_ready3", int'(ir3), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int rr4 [5];
        logic [7:0] held;
        bit keep;
        rr4 = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        mode = 1'b0;
        sel = 2'd0;
        v = 4'h0;
        d = 32'h0;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Fixed select of ch2 with all channels valid.
        mode = 1'b0;
        sel  = 2'd2;
        v    = 4'hF;
        d    = 32'h13_A5_11_10;
        tick();
        chk("fix_data", int'(od4), 8'hA5);
        chk("fix_ch", int'(oc4), 2);

        // Round-robin with every channel valid.
        mode = 1'b1;
        d    = 32'h13_12_11_10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_seq_ch", int'(oc4), rr4[i]);
            chk("rr_seq_data", int'(od4), 8'h10 + rr4[i]);
        end

        // Move dut4 ptr to 2, then only ch1 and ch3 request.
        v = 4'b0010;
        tick();
        v = 4'b1010;
        tick();
        chk("sparse_first", int'(oc4), 3);
        tick();
        chk("sparse_second", int'(oc4), 1);

        // Backpressure: output must freeze while the sink stalls.
        v = 4'hF;
        tick();
        held = od4;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_stable", int'(od4), int'(held));
        end
        out_ready = 1'b1;
        tick();

        // Fixed sel=0 twice, then resume round-robin from the held ptr.
        mode = 1'b0;
        sel  = 2'd0;
        tick();
        tick();
        mode = 1'b1;
        tick();
        tick();

        // sel=3 is out of range for the 3-channel instance.
        mode = 1'b0;
        sel  = 2'd3;
        tick();
        chk("sel_oor_valid3", int'(ov3), 0);
        chk("sel_oor_ch4", int'(oc4), 3);

        // Reset with a word in the output register.
        mode = 1'b1;
        tick();
        chk("pre_rst_valid", int'(ov4), 1);
        do_reset();
        tick();
        chk("post_rst_ch", int'(oc4), 0);

        // Random traffic honouring the hold-until-accepted rule.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 4; i++) begin
                keep = v[i] && (acc[0] != i);
                if (i < 3 && v[i] && acc[1] != i) keep = 1;
                if (!keep) begin
                    v[i] = ($urandom_range(0, 3) != 0);
                    d[i*8 +: 8] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) sel = 2'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
